// File: rtl/pakout_gen_pkg.sv
// Shared types, field widths and helpers for the pakout packet source.
package pakout_gen_pkg;

    localparam int unsigned NS_ADDRESS_SIZE = 8;
    localparam int unsigned NS_DATA_SIZE    = 8;
    localparam int unsigned NS_REDUN_SIZE   = 4;

    // Right-shift Galois tap masks for maximal-length sequences.
    localparam logic [3:0]  NS_LFSR_TAPS_4  = 4'hC;
    localparam logic [7:0]  NS_LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] NS_LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] NS_LFSR_TAPS_32 = 32'h8020_0003;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm  = 3'd1,
        StReq  = 3'd2,
        StRel  = 3'd3,
        StGap  = 3'd4
    } pak_state_e;

    function automatic logic [31:0] ns_lfsr_taps(input int unsigned w);
        case (w)
            4:       return 32'(NS_LFSR_TAPS_4);
            8:       return 32'(NS_LFSR_TAPS_8);
            16:      return 32'(NS_LFSR_TAPS_16);
            32:      return NS_LFSR_TAPS_32;
            default: return 32'h1 << (w - 1);
        endcase
    endfunction

    // Callers keep only the low redundancy bits of the sum.
    function automatic logic [31:0] ns_red_sum(input logic [31:0] src,
                                               input logic [31:0] dst,
                                               input logic [31:0] dat);
        return src + dst + dat;
    endfunction

endpackage

// File: rtl/pakout_gen_lfsr.sv
// Payload register: loads a seed, then steps as a counter or a Galois LFSR.
module pakout_lfsr
    import pakout_gen_pkg::*;
#(
    parameter int unsigned     DSZ  = NS_DATA_SIZE,
    parameter logic [DSZ-1:0]  INIT = 1,
    parameter int unsigned     MODE = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_load,
    input  logic           i_step,
    input  logic [DSZ-1:0] i_seed,
    output logic [DSZ-1:0] o_dat
);

    localparam logic [DSZ-1:0] Taps = DSZ'(ns_lfsr_taps(DSZ));

    logic [DSZ-1:0] dat_q, dat_d;
    logic [DSZ-1:0] galois;

    always_comb begin
        galois = dat_q >> 1;
        if (dat_q[0]) begin
            galois = galois ^ Taps;
        end
    end

    always_comb begin
        dat_d = dat_q;
        if (i_load) begin
            dat_d = i_seed;
        end else if (i_step) begin
            dat_d = (MODE == 0) ? dat_q + 1'b1 : galois;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dat_q <= INIT;
        end else begin
            dat_q <= dat_d;
        end
    end

    assign o_dat = dat_q;

endmodule

// File: rtl/pakout_gen.sv
// Packet source: sweeps dst over a window, drives a four-phase req/ack channel.
module pakout_gen
    import pakout_gen_pkg::*;
#(
    parameter int unsigned MIN_ADDR = 1,
    parameter int unsigned MAX_ADDR = 1,
    parameter int unsigned SRC_ADDR = 3,
    parameter int unsigned INIT_DAT = 5,
    parameter int unsigned DAT_MODE = 0,
    parameter int unsigned GAP      = 0,
    parameter int unsigned CSZ      = 8,
    parameter int unsigned ASZ      = NS_ADDRESS_SIZE,
    parameter int unsigned DSZ      = NS_DATA_SIZE,
    parameter int unsigned RSZ      = NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_stop,
    input  logic [CSZ-1:0] i_npkts,
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    output logic           o_busy,
    output logic           o_done,
    output logic [CSZ-1:0] o_sent
);

    localparam logic [ASZ-1:0] MinA    = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] MaxA    = ASZ'(MAX_ADDR);
    localparam logic [ASZ-1:0] SrcA    = ASZ'(SRC_ADDR);
    localparam logic [DSZ-1:0] InitD   = DSZ'(INIT_DAT);
    localparam logic [7:0]     GapLast = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    pak_state_e     state_q, state_d;
    logic [CSZ-1:0] npkts_q, npkts_d;
    logic [CSZ-1:0] sent_q, sent_d;
    logic           stop_q, stop_d;
    logic [ASZ-1:0] dst_q, dst_d;
    logic [7:0]     gap_q, gap_d;
    logic           done_q, done_d;
    logic           dat_load, dat_step;
    logic [DSZ-1:0] dat;

    pakout_lfsr #(
        .DSZ  (DSZ),
        .INIT (InitD),
        .MODE (DAT_MODE)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (dat_load),
        .i_step (dat_step),
        .i_seed (InitD),
        .o_dat  (dat)
    );

    always_comb begin
        state_d  = state_q;
        npkts_d  = npkts_q;
        sent_d   = sent_q;
        stop_d   = stop_q;
        dst_d    = dst_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        dat_load = 1'b0;
        dat_step = 1'b0;

        if (state_q != StIdle && i_stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    npkts_d  = i_npkts;
                    sent_d   = '0;
                    stop_d   = 1'b0;
                    dst_d    = MinA;
                    dat_load = 1'b1;
                    state_d  = StArm;
                end
            end
            StArm: begin
                if (!o0_ack) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (o0_ack) begin
                    sent_d   = sent_q + 1'b1;
                    dst_d    = (dst_q >= MaxA) ? MinA : dst_q + 1'b1;
                    dat_step = 1'b1;
                    state_d  = StRel;
                end
            end
            StRel: begin
                if (!o0_ack) begin
                    if (stop_q || (npkts_q != '0 && sent_q == npkts_q)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (GAP > 0) begin
                        gap_d   = 8'd0;
                        state_d = StGap;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StArm;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            npkts_q <= '0;
            sent_q  <= '0;
            stop_q  <= 1'b0;
            dst_q   <= MinA;
            gap_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            npkts_q <= npkts_d;
            sent_q  <= sent_d;
            stop_q  <= stop_d;
            dst_q   <= dst_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    assign o0_src = SrcA;
    assign o0_dst = dst_q;
    assign o0_dat = dat;
    assign o0_red = RSZ'(ns_red_sum(32'(SrcA), 32'(dst_q), 32'(dat)));
    assign o0_req = (state_q == StReq);
    assign o_busy = (state_q != StIdle);
    assign o_done = done_q;
    assign o_sent = sent_q;

endmodule

// File: tb/tb_pakout_gen.sv
// Directed bench: counter sweep, gap timing, stop, ack-held start, reset, LFSR payload.
module tb_pakout_gen;
    import pakout_gen_pkg::*;

    localparam int unsigned ASZ = NS_ADDRESS_SIZE;
    localparam int unsigned DSZ = NS_DATA_SIZE;
    localparam int unsigned RSZ = NS_REDUN_SIZE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           a_start, a_stop, a_ack, a_req, a_busy, a_done;
    logic [7:0]     a_npkts, a_sent;
    logic [ASZ-1:0] a_src, a_dst;
    logic [DSZ-1:0] a_dat;
    logic [RSZ-1:0] a_red;

    logic           g_start, g_stop, g_ack, g_req, g_busy, g_done;
    logic [7:0]     g_npkts, g_sent;
    logic [ASZ-1:0] g_src, g_dst;
    logic [DSZ-1:0] g_dat;
    logic [RSZ-1:0] g_red;

    logic           l_start, l_stop, l_ack, l_req, l_busy, l_done;
    logic [7:0]     l_npkts, l_sent;
    logic [ASZ-1:0] l_src, l_dst;
    logic [DSZ-1:0] l_dat;
    logic [RSZ-1:0] l_red;

    // Zero-latency sinks for the gap and LFSR instances.
    assign g_ack = g_req;
    assign l_ack = l_req;

    pakout_gen #(.MIN_ADDR(1), .MAX_ADDR(3), .SRC_ADDR(3), .INIT_DAT(5), .DAT_MODE(0),
                 .GAP(0), .CSZ(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_stop(a_stop), .i_npkts(a_npkts),
        .o0_src(a_src), .o0_dst(a_dst), .o0_dat(a_dat), .o0_red(a_red), .o0_req(a_req),
        .o0_ack(a_ack), .o_busy(a_busy), .o_done(a_done), .o_sent(a_sent)
    );

    pakout_gen #(.MIN_ADDR(1), .MAX_ADDR(3), .SRC_ADDR(3), .INIT_DAT(5), .DAT_MODE(0),
                 .GAP(3), .CSZ(8)) u_gap (
        .i_clk(clk), .i_rst(rst), .i_start(g_start), .i_stop(g_stop), .i_npkts(g_npkts),
        .o0_src(g_src), .o0_dst(g_dst), .o0_dat(g_dat), .o0_red(g_red), .o0_req(g_req),
        .o0_ack(g_ack), .o_busy(g_busy), .o_done(g_done), .o_sent(g_sent)
    );

    pakout_gen #(.MIN_ADDR(1), .MAX_ADDR(3), .SRC_ADDR(3), .INIT_DAT(1), .DAT_MODE(1),
                 .GAP(0), .CSZ(8)) u_lfsr (
        .i_clk(clk), .i_rst(rst), .i_start(l_start), .i_stop(l_stop), .i_npkts(l_npkts),
        .o0_src(l_src), .o0_dst(l_dst), .o0_dat(l_dat), .o0_red(l_red), .o0_req(l_req),
        .o0_ack(l_ack), .o_busy(l_busy), .o_done(l_done), .o_sent(l_sent)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed: dst sweeps 1..3, dat counts from 5, red = (3 + dst + dat) mod 16.
    logic [7:0] t1_dst [4] = '{8'd1, 8'd2, 8'd3, 8'd1};
    logic [7:0] t1_dat [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    logic [3:0] t1_red [4] = '{4'd9, 4'd11, 4'd13, 4'd12};
    logic [7:0] lfsr_tbl [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

    int         n;
    int         low;
    logic [7:0] s;
    logic [7:0] exp_dat;
    logic       zero_seen;

    initial begin
        rst = 1'b1;
        a_start = 0; a_stop = 0; a_ack = 0; a_npkts = 0;
        g_start = 0; g_stop = 0; g_npkts = 0;
        l_start = 0; l_stop = 0; l_npkts = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_req",  32'(a_req),  32'd0);
        check_eq("rst_dst",  32'(a_dst),  32'd1);
        check_eq("rst_dat",  32'(a_dat),  32'd5);
        check_eq("rst_src",  32'(a_src),  32'd3);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_done", 32'(a_done), 32'd0);
        check_eq("rst_sent", 32'(a_sent), 32'd0);
        check_eq("rst_red",  32'(a_red),  32'd9);

        // Four packets, ack one cycle after req.
        a_npkts = 8'd4;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_eq("t1_arm_req",  32'(a_req),  32'd0);
        check_eq("t1_arm_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        check_eq("t1_req_lat", 32'(a_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!a_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            check_eq("t1_req",  32'(a_req),  32'd1);
            check_eq("t1_dst",  32'(a_dst),  32'(t1_dst[i]));
            check_eq("t1_dat",  32'(a_dat),  32'(t1_dat[i]));
            check_eq("t1_red",  32'(a_red),  32'(t1_red[i]));
            check_eq("t1_sent", 32'(a_sent), 32'(i));
            if (i == 1) begin
                a_start = 1'b1;
                a_npkts = 8'd9;
            end
            @(negedge clk);
            a_start = 1'b0;
            check_eq("t1_hold_req", 32'(a_req), 32'd1);
            check_eq("t1_hold_dst", 32'(a_dst), 32'(t1_dst[i]));
            check_eq("t1_hold_dat", 32'(a_dat), 32'(t1_dat[i]));
            a_ack = 1'b1;
            @(negedge clk);
            check_eq("t1_fall", 32'(a_req), 32'd0);
            a_ack = 1'b0;
            @(negedge clk);
        end
        check_eq("t1_done",  32'(a_done), 32'd1);
        check_eq("t1_busy",  32'(a_busy), 32'd0);
        check_eq("t1_sent4", 32'(a_sent), 32'd4);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(a_done), 32'd0);

        // Continuous run; start+stop together keeps running, later stop ends it.
        a_npkts = 8'd0;
        a_start = 1'b1;
        a_stop  = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_stop  = 1'b0;
        @(negedge clk);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        @(negedge clk);
        check_eq("t3_no_early_done", 32'(a_done), 32'd0);
        check_eq("t3_req2", 32'(a_req), 32'd1);
        a_stop = 1'b1;
        a_ack  = 1'b1;
        @(negedge clk);
        a_stop = 1'b0;
        check_eq("t3_fall", 32'(a_req), 32'd0);
        a_ack = 1'b0;
        @(negedge clk);
        check_eq("t3_done", 32'(a_done), 32'd1);
        check_eq("t3_sent", 32'(a_sent), 32'd2);
        repeat (4) @(negedge clk);
        check_eq("t3_idle_req",  32'(a_req),  32'd0);
        check_eq("t3_idle_busy", 32'(a_busy), 32'd0);

        // Ack held high at start: req waits in ARM.
        a_ack   = 1'b1;
        a_npkts = 8'd1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_arm_req", 32'(a_req), 32'd0);
            @(negedge clk);
        end
        a_ack = 1'b0;
        @(negedge clk);
        check_eq("t4_req", 32'(a_req), 32'd1);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        @(negedge clk);
        check_eq("t4_done", 32'(a_done), 32'd1);
        check_eq("t4_sent", 32'(a_sent), 32'd1);

        // Reset while req is high.
        a_npkts = 8'd0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        @(negedge clk);
        check_eq("t5_pre_req", 32'(a_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_req",  32'(a_req),  32'd0);
        check_eq("t5_busy", 32'(a_busy), 32'd0);
        check_eq("t5_sent", 32'(a_sent), 32'd0);
        check_eq("t5_dst",  32'(a_dst),  32'd1);
        check_eq("t5_dat",  32'(a_dat),  32'd5);

        // GAP=3: REL + 3 gap + ARM = 5 low cycles between packets.
        g_npkts = 8'd3;
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!g_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_eq("t2_req", 32'(g_req), 32'd1);
            check_eq("t2_dst", 32'(g_dst), 32'(i + 1));
            @(negedge clk);
            if (i < 2) begin
                low = 0;
                while (!g_req && low < 20) begin
                    low++;
                    @(negedge clk);
                end
                check_eq("t2_gap_low", 32'(low), 32'd5);
            end else begin
                @(negedge clk);
                check_eq("t2_done", 32'(g_done), 32'd1);
                check_eq("t2_sent", 32'(g_sent), 32'd3);
            end
        end

        // LFSR payload over 256 packets; sent wraps to 0.
        s = 8'h01;
        zero_seen = 1'b0;
        l_npkts = 8'd0;
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!l_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            exp_dat = (i < 6) ? lfsr_tbl[i] : s;
            check_eq("t6_lfsr_dat", 32'(l_dat), 32'(exp_dat));
            if (l_dat == 8'h00) begin
                zero_seen = 1'b1;
            end
            s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
            if (i == 255) begin
                l_stop = 1'b1;
            end
            @(negedge clk);
            l_stop = 1'b0;
        end
        @(negedge clk);
        check_eq("t6_done",    32'(l_done),    32'd1);
        check_eq("t6_sent",    32'(l_sent),    32'd0);
        check_eq("t6_nonzero", 32'(zero_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
